// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port text VRAM between VGA fetch, CPU and keyboard echo.
// VGA always wins. Define VRAM_ARB_RR_EN for CPU/KBD round-robin; otherwise CPU > KBD.
module vram_arbiter #(
  parameter int AW           = 13,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk_i,
  input  logic          clrn_i,
  input  logic          vga_req_i,
  input  logic [AW-1:0] vga_addr_i,
  output logic          vga_valid_o,
  output logic [DW-1:0] vga_data_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          kbd_req_i,
  input  logic [AW-1:0] kbd_addr_i,
  input  logic [DW-1:0] kbd_wdata_i,
  output logic          kbd_ack_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          starve_o
);

  typedef enum logic [2:0] {G_NONE, G_VGA, G_CPU_RD, G_CPU_WR, G_KBD} grant_e;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  grant_e      last_grant_q;
  grant_e      grant_d;
  logic        vga_valid_q;
  logic        cpu_ack_q;
  logic        kbd_ack_q;
  logic        starve_q;
  logic        cpu_elig;
  logic        kbd_elig;
  logic        cpu_win;
  logic        kbd_win;
  logic [1:0]  req_vec;
  logic [1:0]  elig_vec;
  logic [1:0]  win_vec;
  logic [1:0]  hit_limit;

  // A held request is masked during its own ack cycle so it cannot be re-granted at N+1.
  assign cpu_elig = cpu_req_i && (last_grant_q != G_CPU_RD) && (last_grant_q != G_CPU_WR);
  assign kbd_elig = kbd_req_i && (last_grant_q != G_KBD);

`ifdef VRAM_ARB_RR_EN
  logic rr_ptr_q;  // 0: CPU preferred, 1: KBD preferred

  always_comb begin
    cpu_win = 1'b0;
    kbd_win = 1'b0;
    if (!vga_req_i) begin
      if (cpu_elig && kbd_elig) begin
        cpu_win = !rr_ptr_q;
        kbd_win = rr_ptr_q;
      end else begin
        cpu_win = cpu_elig;
        kbd_win = kbd_elig;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clrn_i) begin
      rr_ptr_q <= 1'b0;
    end else if (cpu_win) begin
      rr_ptr_q <= 1'b1;
    end else if (kbd_win) begin
      rr_ptr_q <= 1'b0;
    end
  end
`else
  assign cpu_win = !vga_req_i && cpu_elig;
  assign kbd_win = !vga_req_i && !cpu_elig && kbd_elig;
`endif

  always_comb begin
    grant_d = G_NONE;
    if (vga_req_i)    grant_d = G_VGA;
    else if (cpu_win) grant_d = cpu_we_i ? G_CPU_WR : G_CPU_RD;
    else if (kbd_win) grant_d = G_KBD;
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    case (grant_d)
      G_VGA:    ram_addr_o = vga_addr_i;
      G_CPU_RD: ram_addr_o = cpu_addr_i;
      G_CPU_WR: begin
        ram_addr_o  = cpu_addr_i;
        ram_we_o    = 1'b1;
        ram_wdata_o = cpu_wdata_i;
      end
      G_KBD: begin
        ram_addr_o  = kbd_addr_i;
        ram_we_o    = 1'b1;
        ram_wdata_o = kbd_wdata_i;
      end
      default: ;
    endcase
  end

  assign req_vec  = {kbd_req_i, cpu_req_i};
  assign elig_vec = {kbd_elig, cpu_elig};
  assign win_vec  = {kbd_win, cpu_win};

  // Wait counters: index 0 = CPU, 1 = KBD. A withdrawn request clears its count.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_wait
    logic [CW-1:0] wait_q;
    logic [CW-1:0] wait_d;

    always_comb begin
      wait_d = wait_q;
      if (!req_vec[gi] || win_vec[gi]) begin
        wait_d = '0;
      end else if (elig_vec[gi] && (wait_q != LIMIT)) begin
        wait_d = wait_q + CW'(1);
      end
    end

    assign hit_limit[gi] = (wait_d == LIMIT);

    always_ff @(posedge clk_i) begin
      if (!clrn_i) wait_q <= '0;
      else         wait_q <= wait_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clrn_i) begin
      last_grant_q <= G_NONE;
      vga_valid_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      kbd_ack_q    <= 1'b0;
      starve_q     <= 1'b0;
    end else begin
      last_grant_q <= grant_d;
      vga_valid_q  <= (grant_d == G_VGA);
      cpu_ack_q    <= (grant_d == G_CPU_RD) || (grant_d == G_CPU_WR);
      kbd_ack_q    <= (grant_d == G_KBD);
      starve_q     <= starve_q | (|hit_limit);
    end
  end

  assign vga_valid_o = vga_valid_q;
  assign vga_data_o  = vga_valid_q ? ram_rdata_i : '0;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = (last_grant_q == G_CPU_RD) ? ram_rdata_i : '0;
  assign kbd_ack_o   = kbd_ack_q;
  assign starve_o    = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural single-port VRAM.
// Works with or without VRAM_ARB_RR_EN; only the policy scenario changes its expectation.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        vga_req, cpu_req, cpu_we, kbd_req;
  logic [12:0] vga_addr, cpu_addr, kbd_addr;
  logic [15:0] cpu_wdata, kbd_wdata;
  logic        vga_valid, cpu_ack, kbd_ack, ram_we, starve;
  logic [15:0] vga_data, cpu_rdata, ram_wdata, ram_rdata;
  logic [12:0] ram_addr;

  logic        pre_we = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  logic [15:0] mem    [0:8191];
  logic [15:0] shadow [0:8191];
  logic [15:0] vga_q  [$];
  logic [15:0] cpu_q  [$];
  logic [15:0] vga_exp, cpu_exp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk_i(clk), .clrn_i(clrn),
    .vga_req_i(vga_req), .vga_addr_i(vga_addr), .vga_valid_o(vga_valid), .vga_data_o(vga_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .kbd_req_i(kbd_req), .kbd_addr_i(kbd_addr), .kbd_wdata_i(kbd_wdata), .kbd_ack_o(kbd_ack),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .starve_o(starve)
  );

  // Single-port synchronous VRAM; the preload port lets the bench seed contents.
  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Scoreboard: pop the expected word whenever the DUT presents a result.
  always @(negedge clk) begin
    if (vga_valid === 1'b1) begin
      tests++;
      if (vga_q.size() == 0) begin
        fails++;
        $display("FAIL vga_unexpected: got data=%h, required no vga_valid", vga_data);
      end else begin
        vga_exp = vga_q.pop_front();
        if (vga_data !== vga_exp) begin
          fails++;
          $display("FAIL vga_data: got %h, required %h", vga_data, vga_exp);
        end
      end
    end
    if (cpu_ack === 1'b1) begin
      tests++;
      if (cpu_q.size() == 0) begin
        fails++;
        $display("FAIL cpu_unexpected: got rdata=%h, required no cpu_ack", cpu_rdata);
      end else begin
        cpu_exp = cpu_q.pop_front();
        $display("[TB] cpu ack rdata=%h", cpu_rdata);
        if (cpu_rdata !== cpu_exp) begin
          fails++;
          $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, cpu_exp);
        end
      end
    end
    if (kbd_ack === 1'b1) $display("[TB] kbd ack");
  end

  task automatic idle_inputs();
    vga_req = 1'b0; cpu_req = 1'b0; kbd_req = 1'b0; cpu_we = 1'b0;
    vga_addr = '0; cpu_addr = '0; kbd_addr = '0; cpu_wdata = '0; kbd_wdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clrn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    vga_q.delete();
    cpu_q.delete();
  endtask

  task automatic preload(input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d; shadow[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic cpu_xfer(input logic we, input logic [12:0] a, input logic [15:0] wd);
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cpu_q.push_back(we ? 16'h0000 : shadow[a]);
    if (we) shadow[a] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_ack !== 1'b1 && n < 20);
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL cpu_xfer_timeout: got no cpu_ack in %0d cycles, required ack", n);
      cpu_q.delete();
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    vga_req = 1'b1; cpu_req = 1'b1; kbd_req = 1'b1; cpu_we = 1'b1;
    vga_addr = 13'h001; cpu_addr = 13'h002; kbd_addr = 13'h003;
    cpu_wdata = 16'hDEAD; kbd_wdata = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (vga_valid !== 1'b0 || cpu_ack !== 1'b0 || kbd_ack !== 1'b0 || starve !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: got v=%b c=%b k=%b s=%b, required 0000",
                 vga_valid, cpu_ack, kbd_ack, starve);
      end
      tests++;
      if (ram_we !== 1'b0) begin
        fails++;
        $display("FAIL reset_ram_we: got %b, required 0", ram_we);
      end
    end
    @(negedge clk);
    idle_inputs();
    clrn = 1'b1;
  endtask

  task automatic test_cpu_read();
    preload(13'h010, 16'hA541);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
    cpu_q.push_back(shadow[13'h010]);
    #1;
    tests++;
    if (ram_addr !== 13'h010 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_grant: got addr=%h we=%b, required 010/0", ram_addr, ram_we);
    end
    @(negedge clk);
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL cpu_read_ack: got %b, required 1", cpu_ack);
    end
    #1;
    tests++;
    if (ram_addr !== 13'h000 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL cpu_regrant_mask: got addr=%h we=%b, required 000/0", ram_addr, ram_we);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL cpu_ack_pulse: got %b, required 0", cpu_ack);
    end
  endtask

  task automatic test_kbd_write();
    @(negedge clk);
    kbd_req = 1'b1; kbd_addr = 13'h12A; kbd_wdata = 16'h0761;
    shadow[13'h12A] = 16'h0761;
    #1;
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 13'h12A || ram_wdata !== 16'h0761) begin
      fails++;
      $display("FAIL kbd_grant: got we=%b addr=%h wd=%h, required 1/12a/0761",
               ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    tests++;
    if (kbd_ack !== 1'b1) begin
      fails++;
      $display("FAIL kbd_ack: got %b, required 1", kbd_ack);
    end
    kbd_req = 1'b0;
    @(negedge clk);
    tests++;
    if (kbd_ack !== 1'b0) begin
      fails++;
      $display("FAIL kbd_ack_pulse: got %b, required 0", kbd_ack);
    end
    cpu_xfer(1'b0, 13'h12A, 16'h0000);
  endtask

  task automatic test_starve();
    logic [12:0] a;
    logic        exp_s;
    for (int i = 0; i <= 70; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if (vga_valid !== 1'b1 || cpu_ack !== 1'b0) begin
          fails++;
          $display("FAIL starve_vga_wins[%0d]: got v=%b c=%b, required 1/0", i, vga_valid, cpu_ack);
        end
        exp_s = (i >= 64);
        tests++;
        if (starve !== exp_s) begin
          fails++;
          $display("FAIL starve_flag[%0d]: got %b, required %b", i, starve, exp_s);
        end
      end
      if (i < 70) begin
        a = (i % 2 == 1) ? 13'h12A : 13'h010;
        vga_req = 1'b1; vga_addr = a;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
        vga_q.push_back(shadow[a]);
      end
    end
    vga_req = 1'b0;
    cpu_q.push_back(shadow[13'h010]);
    #1;
    tests++;
    if (ram_addr !== 13'h010 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL starve_cpu_grant: got addr=%h we=%b, required 010/0", ram_addr, ram_we);
    end
    @(negedge clk);
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL starve_cpu_ack: got %b, required 1", cpu_ack);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_withdraw();
    apply_reset();
    for (int i = 0; i < 74; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if (cpu_ack !== 1'b0) begin
          fails++;
          $display("FAIL withdraw_no_ack[%0d]: got %b, required 0", i, cpu_ack);
        end
      end
      // Gaps at cycles 3-4 (both idle) and 64 (CPU withdrawn while VGA continues).
      vga_req  = !(i == 3 || i == 4);
      vga_addr = 13'h010;
      cpu_req  = !(i == 3 || i == 4 || i == 64);
      cpu_we = 1'b0; cpu_addr = 13'h010;
      if (vga_req) vga_q.push_back(shadow[13'h010]);
    end
    @(negedge clk);
    tests++;
    if (starve !== 1'b0) begin
      fails++;
      $display("FAIL withdraw_counter_clear: got starve=%b, required 0", starve);
    end
    vga_req = 1'b0;
    cpu_q.push_back(shadow[13'h010]);
    @(negedge clk);
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL withdraw_final_ack: got %b, required 1", cpu_ack);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    int         g, n;
    apply_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
    kbd_req = 1'b1; kbd_addr = 13'h200; kbd_wdata = 16'h1111;
    shadow[13'h200] = 16'h1111;
    cpu_q.push_back(shadow[13'h010]);
    cpu_q.push_back(shadow[13'h010]);
    seq = '0; g = 0; n = 0;
    while (g < 4 && n < 12) begin
      @(negedge clk);
      n++;
      tests++;
      if (cpu_ack === 1'b1 && kbd_ack === 1'b1) begin
        fails++;
        $display("FAIL b2b_double_ack: got cpu_ack=1 kbd_ack=1, required at most one");
      end
      if (cpu_ack === 1'b1) begin
        seq = {seq[5:0], 2'b01}; g++;
      end else if (kbd_ack === 1'b1) begin
        seq = {seq[5:0], 2'b10}; g++;
      end
    end
    cpu_req = 1'b0; kbd_req = 1'b0;
    tests++;
    if (seq !== 8'b01_10_01_10) begin
      fails++;
      $display("FAIL b2b_order: got %b, required 01100110 (C,K,C,K)", seq);
    end
    cpu_xfer(1'b0, 13'h200, 16'h0000);
  endtask

  task automatic test_policy();
    int n;
    logic cpu_done, kbd_done;
    apply_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
    cpu_q.push_back(shadow[13'h010]);
    @(negedge clk);
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++;
      $display("FAIL policy_first_ack: got %b, required 1", cpu_ack);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; kbd_req = 1'b1; kbd_addr = 13'h201; kbd_wdata = 16'h2222;
    shadow[13'h201] = 16'h2222;
    cpu_q.push_back(shadow[13'h010]);
    #1;
    tests++;
`ifdef VRAM_ARB_RR_EN
    if (ram_addr !== 13'h201 || ram_we !== 1'b1) begin
      fails++;
      $display("FAIL policy_rr_kbd: got addr=%h we=%b, required 201/1", ram_addr, ram_we);
    end
`else
    if (ram_addr !== 13'h010 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL policy_fixed_cpu: got addr=%h we=%b, required 010/0", ram_addr, ram_we);
    end
`endif
    cpu_done = 1'b0; kbd_done = 1'b0; n = 0;
    while (!(cpu_done && kbd_done) && n < 6) begin
      @(negedge clk);
      n++;
      if (cpu_ack === 1'b1) begin cpu_done = 1'b1; cpu_req = 1'b0; end
      if (kbd_ack === 1'b1) begin kbd_done = 1'b1; kbd_req = 1'b0; end
    end
    cpu_req = 1'b0; kbd_req = 1'b0;
    tests++;
    if (!(cpu_done && kbd_done)) begin
      fails++;
      $display("FAIL policy_both_served: got cpu=%b kbd=%b, required 1/1", cpu_done, kbd_done);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h300; cpu_wdata = 16'hBEEF;
    shadow[13'h300] = 16'hBEEF;
    #1;
    tests++;
    if (ram_we !== 1'b1 || ram_addr !== 13'h300 || ram_wdata !== 16'hBEEF) begin
      fails++;
      $display("FAIL abort_grant: got we=%b addr=%h wd=%h, required 1/300/beef",
               ram_we, ram_addr, ram_wdata);
    end
    #1;
    clrn = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_ack !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_ack: got %b, required 0", cpu_ack);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    tests++;
    if (cpu_ack !== 1'b0 || starve !== 1'b0) begin
      fails++;
      $display("FAIL abort_after: got ack=%b starve=%b, required 0/0", cpu_ack, starve);
    end
    cpu_xfer(1'b0, 13'h300, 16'h0000);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_kbd_write();
    test_starve();
    test_withdraw();
    test_back_to_back();
    test_policy();
    test_reset_abort();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (vga_q.size() != 0 || cpu_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got vga=%0d cpu=%0d pending, required 0/0",
               vga_q.size(), cpu_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
